note_judge: RTL

- Producer end of the note-match interface; the note-display string block consumes its match_en/match_time pair.
- Walks the same note_times/note_frets song memories from a head pointer.
- Compares the player's strum and fret state against the head note inside a timing window, then emits a one-cycle match pulse carrying the matched note's time.
- Also issues miss pulses and keeps hit/miss/streak counters for the score display; one instance per string.

---
 rtl/note_judge_pkg.sv | 9 +
 rtl/note_judge_sat_counter.sv | 14 +
 rtl/note_judge.sv | 82 ++++++++
 3 files changed

// File: rtl/note_judge_pkg.sv
// note_judge_pkg: widths, song-end sentinel and judge states shared with the
// display string block so match_time means the same thing at both ends.
package note_judge_pkg;
  localparam int TIME_W = 16;
  localparam int FRET_W = 5;
  localparam int ADDR_W = 5;
  localparam logic [TIME_W-1:0] END_TIME = 16'hFFFF;
  typedef enum logic [1:0] {LOAD, ARMED, DONE} state_t;
endpackage

// File: rtl/note_judge_sat_counter.sv
// sat_counter: up counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk65,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk65)
    if (reset || clr) q <= '0;
    else if (inc && !(&q)) q <= q + W'(1);
endmodule

// File: rtl/note_judge.sv
// note_judge: per-string note judge; walks the song memory from a head pointer,
// grades strums against the head note and emits match/miss pulses and counters.
module note_judge
  import note_judge_pkg::*;
#(
  parameter int WINDOW       = 10,
  parameter int NUM_NOTES    = 32,
  parameter int READ_LATENCY = 2,
  parameter logic [TIME_W-1:0] END_TIME = note_judge_pkg::END_TIME
) (
  input  logic              clk65,
  input  logic              reset,
  input  logic [TIME_W-1:0] song_time,
  input  logic              strum,
  input  logic [FRET_W-1:0] fret_in,
  output logic [ADDR_W-1:0] note_addr,
  input  logic [TIME_W-1:0] note_time,
  input  logic [FRET_W-1:0] note_fret,
  output logic              match_en,
  output logic [TIME_W-1:0] match_time,
  output logic              miss,
  output logic [9:0]        hit_count,
  output logic [9:0]        miss_count,
  output logic [7:0]        streak,
  output logic              done
);
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [TIME_W:0] WIN = (TIME_W + 1)'(WINDOW);
  state_t state, state_n;
  logic [ADDR_W-1:0] head;
  logic [TIME_W-1:0] head_time;
  logic [FRET_W-1:0] head_fret;
  logic [CW-1:0] cnt;
  logic pend, load_done, try_now, good, hit, bad, late, expire, last;
  logic signed [TIME_W:0] diff;
  // 17-bit arithmetic keeps the window exact right up to 16'hFFFF
  assign diff = $signed({1'b0, song_time}) - $signed({1'b0, head_time});
  assign late = {1'b0, song_time} > ({1'b0, head_time} + WIN);
  assign good = diff <= $signed(WIN) && diff >= -$signed(WIN) && fret_in == head_fret;
  assign try_now = state == ARMED && (strum || pend);
  assign hit = try_now && good;
  assign bad = try_now && !good;
  assign expire = state == ARMED && !try_now && late;
  assign load_done = state == LOAD && cnt == CW'(READ_LATENCY);
  assign last = head == ADDR_W'(NUM_NOTES - 1);
  assign note_addr = head;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    if (state == LOAD) state_n = load_done ? (note_time == END_TIME ? DONE : ARMED) : LOAD;
    else if (hit || expire) state_n = last ? DONE : LOAD;
  end
  always_ff @(posedge clk65) begin
    if (reset) begin
      state      <= LOAD;
      head       <= '0;
      head_time  <= '0;
      head_fret  <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      match_en   <= 1'b0;
      match_time <= '0;
      miss       <= 1'b0;
    end else begin
      state    <= state_n;
      match_en <= hit;
      miss     <= bad || expire;
      // strums seen while the next note is still being fetched wait in pend
      pend     <= state == LOAD && (pend || strum);
      cnt      <= (state == LOAD && !load_done) ? cnt + CW'(1) : '0;
      if (hit) match_time <= head_time;
      if (load_done) begin
        head_time <= note_time;
        head_fret <= note_fret;
      end
      if ((hit || expire) && !last) head <= head + ADDR_W'(1);
    end
  end
  sat_counter #(.W(10)) u_hits (.clk65(clk65), .reset(reset), .inc(hit), .clr(1'b0), .q(hit_count));
  sat_counter #(.W(10)) u_misses (.clk65(clk65), .reset(reset), .inc(bad || expire), .clr(1'b0), .q(miss_count));
  sat_counter #(.W(8)) u_streak (.clk65(clk65), .reset(reset), .inc(hit), .clr(bad || expire), .q(streak));
endmodule
